// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a host/loader port.
// CPU wins by default; a host wait counter forces host grants, and the host may lock bursts.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic              host_lock_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(MAX_LOCK);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  owner_t              rd_owner_p0, rd_owner_p1;
  logic                cpu_gnt, host_gnt;

  // Grant stage: decide the owner of the memory port this cycle
  always_comb begin
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_ARB: begin
        if (host_req_i && (wait_cnt_q == WAIT_LIM)) begin
          host_gnt = 1'b1;
        end else if (cpu_req_i) begin
          cpu_gnt = 1'b1;
        end else if (host_req_i) begin
          host_gnt = 1'b1;
        end
        if (host_req_i && !host_gnt) begin
          wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
        if (host_gnt && host_lock_i) begin
          state_d    = ST_LOCK;
          lock_cnt_d = LOCK_W'(1);
        end
      end
      ST_LOCK: begin
        // Release cycle hands the port straight to the CPU; the host gets nothing this cycle
        if (!host_lock_i || (lock_cnt_q == LOCK_LIM)) begin
          cpu_gnt    = cpu_req_i;
          state_d    = ST_ARB;
          lock_cnt_d = '0;
          wait_cnt_d = '0;
        end else if (host_req_i) begin
          host_gnt   = 1'b1;
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    mem_re_o    = (cpu_gnt && !cpu_we_i) || (host_gnt && !host_we_i);
    mem_we_o    = (cpu_gnt && cpu_we_i) || (host_gnt && host_we_i);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rd_owner_p0 = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      if (!cpu_we_i) rd_owner_p0 = OWN_CPU;
    end else if (host_gnt) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
      if (!host_we_i) rd_owner_p0 = OWN_HOST;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARB;
      wait_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      rd_owner_p1 <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      rd_owner_p1 <= rd_owner_p0;
    end
  end

  // Return stage: memory data arrives one cycle after the read grant
  assign cpu_gnt_o     = cpu_gnt;
  assign host_gnt_o    = host_gnt;
  assign cpu_stall_o   = cpu_req_i && !cpu_gnt;
  assign cpu_rvalid_o  = (rd_owner_p1 == OWN_CPU);
  assign host_rvalid_o = (rd_owner_p1 == OWN_HOST);
  assign cpu_rdata_o   = cpu_rvalid_o ? mem_rdata_i : '0;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized
// requesters checked every cycle against a counter/array reference model.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 16;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        host_req, host_we, host_lock;
  logic [7:0]  host_addr;
  logic [63:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [63:0] host_rdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // reference model state
  int          m_waited, m_beats;
  bit          m_locked, m_pcpu, m_phost;
  logic [63:0] m_pdata;
  logic [63:0] ref_mem [256];
  bit          last_cg, last_hg;
  bit          u_cg, u_hg, c_cg, c_hg;
  logic [63:0] mem_arr [256];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_lock_i(host_lock), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata), .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] preload(input int i);
    if (i == 16) return 64'hA5;
    return 64'h1000 + 64'(i);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single-port memory with one cycle read latency; garbage on the bus when idle
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = preload(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem_arr[mem_addr];
      else        mem_rdata <= {$urandom(), $urandom()};
    end
  end

  // Who owns the memory this cycle, from the counters of the model
  function automatic void model_grants(output bit cg, output bit hg);
    cg = 1'b0;
    hg = 1'b0;
    if (m_locked) begin
      if (!host_lock || m_beats >= MAX_LOCK) cg = cpu_req;
      else                                   hg = host_req;
    end else begin
      hg = host_req && (m_waited >= MAX_WAIT || !cpu_req);
      cg = cpu_req && !hg;
    end
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
    m_waited = 0; m_beats = 0; m_locked = 0; m_pcpu = 0; m_phost = 0; m_pdata = '0;
    last_cg = 0; last_hg = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_waited = 0; m_beats = 0; m_locked = 0; m_pcpu = 0; m_phost = 0; m_pdata = '0;
        last_cg = 0; last_hg = 0;
      end else begin
        model_grants(u_cg, u_hg);
        m_pcpu  = u_cg && !cpu_we;
        m_phost = u_hg && !host_we;
        if (m_pcpu)       m_pdata = ref_mem[cpu_addr];
        else if (m_phost) m_pdata = ref_mem[host_addr];
        else              m_pdata = '0;
        if (u_cg && cpu_we)  ref_mem[cpu_addr]  = cpu_wdata;
        if (u_hg && host_we) ref_mem[host_addr] = host_wdata;
        if (m_locked) begin
          if (!host_lock || m_beats >= MAX_LOCK) begin
            m_locked = 0; m_beats = 0; m_waited = 0;
          end else if (u_hg) begin
            m_beats++;
          end
        end else if (u_hg) begin
          m_waited = 0;
          if (host_lock) begin m_locked = 1; m_beats = 1; end
        end else if (host_req) begin
          m_waited = (m_waited < MAX_WAIT) ? m_waited + 1 : MAX_WAIT;
        end else begin
          m_waited = 0;
        end
        last_cg = u_cg;
        last_hg = u_hg;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        model_grants(c_cg, c_hg);
        chk1("cpu_gnt", cpu_gnt, c_cg);
        chk1("host_gnt", host_gnt, c_hg);
        chk1("cpu_stall", cpu_stall, cpu_req && !c_cg);
        chk1("mem_re", mem_re, (c_cg && !cpu_we) || (c_hg && !host_we));
        chk1("mem_we", mem_we, (c_cg && cpu_we) || (c_hg && host_we));
        chk64("mem_addr", {56'h0, mem_addr},
              c_cg ? {56'h0, cpu_addr} : (c_hg ? {56'h0, host_addr} : 64'h0));
        chk64("mem_wdata", mem_wdata, c_cg ? cpu_wdata : (c_hg ? host_wdata : 64'h0));
        chk1("cpu_rvalid", cpu_rvalid, m_pcpu);
        chk1("host_rvalid", host_rvalid, m_phost);
        chk64("cpu_rdata", cpu_rdata, m_pcpu ? m_pdata : 64'h0);
        chk64("host_rdata", host_rdata, m_phost ? m_pdata : 64'h0);
      end
    end
  end

  task automatic idle(input int n);
    cpu_req = 0; host_req = 0; host_lock = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [9:0]  hpat, cpat;
  logic [20:0] hb, cb;
  int          stalls, cpu_pct, host_pct;

  initial begin
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_host_rvalid", host_rvalid, 1'b0);
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #3;
    rst_n = 1;

    // CPU-only read of the preloaded word
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    chk1("t1_gnt", cpu_gnt, 1'b1);
    chk1("t1_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    chk1("t1_rvalid", cpu_rvalid, 1'b1);
    chk64("t1_rdata", cpu_rdata, 64'hA5);

    // Both requesting: host forced every fifth cycle
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    host_req = 1; host_we = 0; host_lock = 0; host_addr = 8'h41;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hpat[i] = host_gnt;
      cpat[i] = cpu_gnt;
      if (cpu_stall) stalls++;
      @(posedge clk); #1;
    end
    chk64("t2_host_pattern", {54'h0, hpat}, 64'h210);
    chk64("t2_cpu_pattern", {54'h0, cpat}, 64'h1EF);
    chk64("t2_stalls", 64'(stalls), 64'd2);
    idle(1);

    // Locked host write burst against a continuously requesting CPU
    host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'h00; host_wdata = 64'hB000;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      hb[i] = host_gnt;
      cb[i] = cpu_gnt;
      @(posedge clk); #1;
      if (last_hg) begin
        host_addr  = host_addr + 8'd1;
        host_wdata = 64'hB000 + {56'h0, host_addr};
      end
    end
    chk64("t3_host_window", {43'h0, hb}, 64'h0FFFF0);
    chk64("t3_cpu_window", {43'h0, cb}, 64'h10000F);
    cpu_req = 0;
    for (int n = 0; n < 40 && host_addr < 8'd20; n++) begin
      @(posedge clk); #1;
      if (last_hg) begin
        host_addr  = host_addr + 8'd1;
        host_wdata = 64'hB000 + {56'h0, host_addr};
      end
    end
    chk64("t3_burst_done", {56'h0, host_addr}, 64'd20);
    idle(2);

    // Back-to-back reads from different ports
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    @(negedge clk);
    chk1("t4_cpu_gnt", cpu_gnt, 1'b1);
    @(posedge clk); #1;
    cpu_req = 0;
    host_req = 1; host_we = 0; host_lock = 0; host_addr = 8'h02;
    @(negedge clk);
    chk1("t4_host_gnt", host_gnt, 1'b1);
    chk1("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    chk64("t4_cpu_rdata", cpu_rdata, 64'hB001);
    chk1("t4_host_rvalid_idle", host_rvalid, 1'b0);
    chk64("t4_host_rdata_idle", host_rdata, 64'h0);
    @(posedge clk); #1;
    host_req = 0;
    @(negedge clk);
    chk1("t4_host_rvalid", host_rvalid, 1'b1);
    chk64("t4_host_rdata", host_rdata, 64'hB002);
    chk1("t4_cpu_rvalid_idle", cpu_rvalid, 1'b0);
    chk64("t4_cpu_rdata_idle", cpu_rdata, 64'h0);
    idle(1);

    // Host write then CPU read of the same word
    host_req = 1; host_we = 1; host_lock = 0; host_addr = 8'h20; host_wdata = 64'hDEAD;
    @(posedge clk); #1;
    host_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    chk64("t5_rdata", cpu_rdata, 64'hDEAD);
    idle(1);

    // Asynchronous reset during a locked burst with a read outstanding
    host_req = 1; host_we = 0; host_lock = 1; host_addr = 8'h05;
    @(posedge clk); #1;
    host_addr = 8'h06;
    #1;
    chk1("t6_rvalid_pre", host_rvalid, 1'b1);
    chk64("t6_rdata_pre", host_rdata, 64'hB005);
    @(posedge clk); #1;
    host_req = 0; host_lock = 0;
    #1;
    chk1("t6_pending", host_rvalid, 1'b1);
    #1;
    rst_n = 0;
    #1;
    chk1("t6_host_rvalid_rst", host_rvalid, 1'b0);
    chk64("t6_host_rdata_rst", host_rdata, 64'h0);
    chk1("t6_cpu_rvalid_rst", cpu_rvalid, 1'b0);
    chk1("t6_host_gnt_rst", host_gnt, 1'b0);
    chk1("t6_mem_re_rst", mem_re, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h07;
    host_req = 1; host_we = 0; host_lock = 1; host_addr = 8'h08;
    @(negedge clk);
    chk1("t6_cpu_first", cpu_gnt, 1'b1);
    chk1("t6_host_waits", host_gnt, 1'b0);
    @(posedge clk); #1;
    idle(2);

    // Randomized requesters honouring hold-until-granted
    cpu_pct = 50; host_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        cpu_pct  = int'($urandom_range(100, 20));
        host_pct = int'($urandom_range(100, 20));
      end
      @(posedge clk); #1;
      if (!cpu_req || last_cg) begin
        if (int'($urandom_range(99)) < cpu_pct) begin
          cpu_req   = 1;
          cpu_we    = 1'($urandom_range(1));
          cpu_addr  = 8'($urandom_range(31));
          cpu_wdata = {$urandom(), $urandom()};
        end else begin
          cpu_req = 0;
        end
      end
      if (!host_req || last_hg) begin
        if (int'($urandom_range(99)) < host_pct) begin
          host_req   = 1;
          host_we    = 1'($urandom_range(1));
          host_addr  = 8'($urandom_range(31));
          host_wdata = {$urandom(), $urandom()};
        end else begin
          host_req = 0;
        end
      end
      if ($urandom_range(15) == 0) host_lock = ~host_lock;
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
